// File: rtl/morse_decoder_hs.sv
// Morse key decoder with programmable timing.
// Raw key -> 2-FF synchroniser -> debouncer -> edge timer -> IDLE/PRESS/GAP
// FSM that collects dots and dashes. Each finished character is decoded to
// ASCII and presented on a single-entry valid/ready output register.
module morse_decoder_hs #(
  parameter int UNIT_TICKS     = 5000000,  // cycles per Morse time unit U (>= 4)
  parameter int DEBOUNCE_TICKS = 500000,   // stable cycles before a level change (>= 1)
  parameter int MAX_SYMBOLS    = 5,        // symbols per character (5..7)
  parameter int CNT_W          = 32        // timer width, must hold 8*UNIT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       morse_in,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       button_pressed,
  output logic       overrun,
  output logic [2:0] sym_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // The timer reads N-1 in the N-th cycle of a level, so thresholds sit one below
  // the nominal length: a press of 2U cycles is the first dash, a gap of 3U cycles
  // the first that closes a character.
  localparam logic [CNT_W-1:0] T_DASH = CNT_W'(2 * UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] T_CHAR = CNT_W'(3 * UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] T_WORD = CNT_W'(7 * UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] T_SAT  = CNT_W'(8 * UNIT_TICKS);

  localparam logic [2:0] SYM_MAX = 3'(MAX_SYMBOLS);

  localparam int               DB_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  logic [1:0]             sync_q;
  logic                   db_level;
  logic [DB_W-1:0]        db_cnt;
  logic                   db_load;
  logic                   rise_evt;
  logic                   fall_evt;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             state;
  logic [MAX_SYMBOLS-1:0] pattern;
  logic                   err;
  logic                   word_pending;
  logic                   dash_bit;
  logic                   letter_evt;
  logic                   space_evt;
  logic                   emit_evt;
  logic [7:0]             emit_code;

  // International Morse lookup; pattern holds the first symbol in the MSB of the
  // used bits (dot = 0, dash = 1), unused upper bits are always zero.
  function automatic logic [7:0] decode(input logic [2:0] len, input logic [4:0] p);
    logic [7:0] c;
    c = 8'h3F;
    case ({len, p})
      {3'd1, 5'b00000}: c = 8'h45;  // E
      {3'd1, 5'b00001}: c = 8'h54;  // T
      {3'd2, 5'b00000}: c = 8'h49;  // I
      {3'd2, 5'b00001}: c = 8'h41;  // A
      {3'd2, 5'b00010}: c = 8'h4E;  // N
      {3'd2, 5'b00011}: c = 8'h4D;  // M
      {3'd3, 5'b00000}: c = 8'h53;  // S
      {3'd3, 5'b00001}: c = 8'h55;  // U
      {3'd3, 5'b00010}: c = 8'h52;  // R
      {3'd3, 5'b00011}: c = 8'h57;  // W
      {3'd3, 5'b00100}: c = 8'h44;  // D
      {3'd3, 5'b00101}: c = 8'h4B;  // K
      {3'd3, 5'b00110}: c = 8'h47;  // G
      {3'd3, 5'b00111}: c = 8'h4F;  // O
      {3'd4, 5'b00000}: c = 8'h48;  // H
      {3'd4, 5'b00001}: c = 8'h56;  // V
      {3'd4, 5'b00010}: c = 8'h46;  // F
      {3'd4, 5'b00100}: c = 8'h4C;  // L
      {3'd4, 5'b00110}: c = 8'h50;  // P
      {3'd4, 5'b00111}: c = 8'h4A;  // J
      {3'd4, 5'b01000}: c = 8'h42;  // B
      {3'd4, 5'b01001}: c = 8'h58;  // X
      {3'd4, 5'b01010}: c = 8'h43;  // C
      {3'd4, 5'b01011}: c = 8'h59;  // Y
      {3'd4, 5'b01100}: c = 8'h5A;  // Z
      {3'd4, 5'b01101}: c = 8'h51;  // Q
      {3'd5, 5'b00000}: c = 8'h35;  // 5
      {3'd5, 5'b00001}: c = 8'h34;  // 4
      {3'd5, 5'b00011}: c = 8'h33;  // 3
      {3'd5, 5'b00111}: c = 8'h32;  // 2
      {3'd5, 5'b01111}: c = 8'h31;  // 1
      {3'd5, 5'b10000}: c = 8'h36;  // 6
      {3'd5, 5'b11000}: c = 8'h37;  // 7
      {3'd5, 5'b11100}: c = 8'h38;  // 8
      {3'd5, 5'b11110}: c = 8'h39;  // 9
      {3'd5, 5'b11111}: c = 8'h30;  // 0
      default:          c = 8'h3F;  // ?
    endcase
    return c;
  endfunction

  // Two-stage synchroniser for the asynchronous key input.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], morse_in};
  end

  // Debounce event and level edges; a rise or fall is the cycle db_level is about to flip.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    db_load  = 1'b0;
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    dash_bit = 1'b0;
    if ((sync_q[1] != db_level) && (db_cnt == DB_LAST)) db_load = 1'b1;
    rise_evt = db_load && !db_level;
    fall_evt = db_load &&  db_level;
    dash_bit = (cnt >= T_DASH);
  end

  // Debouncer: any return to the current level restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (db_load) begin
      db_level <= sync_q[1];
      db_cnt   <= '0;
    end else if (sync_q[1] != db_level) begin
      db_cnt   <= db_cnt + 1'b1;
    end else begin
      db_cnt   <= '0;
    end
  end

  // Cycles spent at the current debounced level, saturating instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (db_load)      cnt <= '0;
    else if (cnt != T_SAT) cnt <= cnt + 1'b1;
  end

  // Character and word completion events, and the code that goes with them.
  always_comb begin
    letter_evt = (state == S_GAP) && (cnt == T_CHAR) && (sym_count != 3'd0);
    space_evt  = (state == S_GAP) && (cnt == T_WORD) && word_pending;
    emit_evt   = letter_evt || space_evt;
    emit_code  = 8'h3F;
    if (space_evt)  emit_code = 8'h20;
    else if (!err)  emit_code = decode(sym_count, pattern[4:0]);
  end

  // Symbol collection FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pattern      <= '0;
      sym_count    <= 3'd0;
      err          <= 1'b0;
      word_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise_evt) state <= S_PRESS;
        end
        S_PRESS: begin
          if (fall_evt) begin
            pattern <= {pattern[MAX_SYMBOLS-2:0], dash_bit};
            if (sym_count == SYM_MAX) err <= 1'b1;
            else                      sym_count <= sym_count + 3'd1;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (letter_evt) begin
            pattern      <= '0;
            sym_count    <= 3'd0;
            err          <= 1'b0;
            word_pending <= 1'b1;
          end
          if (cnt == T_WORD) begin
            word_pending <= 1'b0;
            state        <= S_IDLE;
          end
          // A rise always wins: it either continues the character or, on the
          // very cycle the character closed, starts the next one.
          if (rise_evt) state <= S_PRESS;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single-entry output register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_char <= 8'h00;
      char_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (emit_evt) begin
      if (!char_valid || char_ready) begin
        ascii_char <= emit_code;
        char_valid <= 1'b1;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (char_valid && char_ready) begin
      char_valid <= 1'b0;
    end
  end

  assign button_pressed = db_level;

endmodule

// File: tb/tb_morse_decoder_hs.sv
// Self-checking bench for morse_decoder_hs with U=10, debounce=3.
// Delivered characters are compared against a queue of expected codes pushed
// as the key stimulus is driven.
module tb_morse_decoder_hs;

  localparam int U = 10;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       morse_in;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       char_ready;
  logic       button_pressed;
  logic       overrun;
  logic [2:0] sym_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    string      sym;
    int         dot_len;
    int         dash_len;
    int         gap;
    logic [7:0] code;
  } vec_t;

  vec_t vecs[12];

  morse_decoder_hs #(
    .UNIT_TICKS(U),
    .DEBOUNCE_TICKS(D),
    .MAX_SYMBOLS(5),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .morse_in(morse_in),
    .ascii_char(ascii_char),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .button_pressed(button_pressed),
    .overrun(overrun),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string s, input int dl, input int hl, input int g,
                              input logic [7:0] c);
    vec_t v;
    v.sym = s; v.dot_len = dl; v.dash_len = hl; v.gap = g; v.code = c;
    return v;
  endfunction

  // Drive a key level for n cycles; inputs change 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    morse_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key one character: intra-character gaps of 'gap', then a trailing gap.
  task automatic send(input string s, input int dl, input int hl, input int gap, input int tail);
    for (int i = 0; i < s.len(); i++) begin
      hold(1'b1, (s[i] == "-") ? hl : dl);
      hold(1'b0, (i == s.len() - 1) ? tail : gap);
    end
  endtask

  // Bounded wait until every expected character has been delivered.
  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard: a transfer happens on the next rising edge when valid&&ready here.
  always @(negedge clk) begin
    if (!reset && char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer: got 0x%0h expected nothing queued", ascii_char);
      end else begin
        logic [7:0] want;
        want = exp_q.pop_front();
        check("xfer", ascii_char, want);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(".",     19, 30, 10, 8'h45);  // longest dot -> E
    vecs[1]  = mk("-",     10, 20, 10, 8'h54);  // shortest dash -> T
    vecs[2]  = mk("..",    10, 30, 29, 8'h49);  // longest intra gap -> I
    vecs[3]  = mk("-.-.",  10, 30, 10, 8'h43);  // C
    vecs[4]  = mk("--.-",  10, 30, 10, 8'h51);  // Q
    vecs[5]  = mk("-----", 10, 30, 10, 8'h30);  // 0
    vecs[6]  = mk("..---", 10, 30, 10, 8'h32);  // 2
    vecs[7]  = mk("...-",  10, 30, 10, 8'h56);  // V
    vecs[8]  = mk(".-.",   10, 100, 10, 8'h52); // R with saturated long press
    vecs[9]  = mk("-..-",  10, 30, 10, 8'h58);  // X
    vecs[10] = mk(".----", 10, 30, 10, 8'h31);  // 1
    vecs[11] = mk("..--",  10, 30, 10, 8'h3F);  // unmapped -> ?

    reset      = 1'b1;
    morse_in   = 1'b0;
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ascii",   ascii_char,     8'h00);
    check("rst_valid",   char_valid,     1'b0);
    check("rst_button",  button_pressed, 1'b0);
    check("rst_overrun", overrun,        1'b0);
    check("rst_symcnt",  sym_count,      3'd0);
    reset = 1'b0;
    hold(1'b0, 5);

    // A followed by a word space.
    exp_q.push_back(8'h41);
    hold(1'b1, 10); hold(1'b0, 15); hold(1'b1, 30); hold(1'b0, 40);
    exp_q.push_back(8'h20);
    hold(1'b0, 60);
    wait_empty("t1_drain");
    check("t1_overrun", overrun, 1'b0);

    // Five dots -> '5'; six dots -> '?' with the symbol count held at its limit.
    exp_q.push_back(8'h35);
    send(".....", 10, 30, 10, 35);
    exp_q.push_back(8'h3F);
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    check("t2_symcnt_sat", sym_count, 3'd5);
    hold(1'b0, 25);
    exp_q.push_back(8'h20);
    hold(1'b0, 80);
    wait_empty("t2_drain");

    // Table of characters, back to back, then one word space.
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(vecs[i].code);
      send(vecs[i].sym, vecs[i].dot_len, vecs[i].dash_len, vecs[i].gap, 35);
    end
    exp_q.push_back(8'h20);
    hold(1'b0, 80);
    wait_empty("table_drain");

    // Gap of exactly 3U between two dots splits them into E, E.
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h45);
    hold(1'b1, 10); hold(1'b0, 30); hold(1'b1, 10); hold(1'b0, 35);
    exp_q.push_back(8'h20);
    hold(1'b0, 80);
    wait_empty("t5_drain");

    // Bounce then a stable press: debounced level rises 2+3 cycles after stable.
    exp_q.push_back(8'h54);
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    check("t3_no_bounce", button_pressed, 1'b0);
    morse_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t3_btn_early", button_pressed, 1'b0);
    @(posedge clk);
    #1;
    check("t3_btn_rise", button_pressed, 1'b1);
    hold(1'b1, 35);
    hold(1'b0, 35);
    exp_q.push_back(8'h20);
    hold(1'b0, 80);
    wait_empty("t3_drain");

    // Consumer stalled: T is dropped and overrun sticks; only E transfers.
    char_ready = 1'b0;
    exp_q.push_back(8'h45);
    hold(1'b1, 10); hold(1'b0, 35);
    hold(1'b1, 30); hold(1'b0, 80);
    check("t4_ascii_held", ascii_char, 8'h45);
    check("t4_valid",      char_valid, 1'b1);
    check("t4_overrun",    overrun,    1'b1);
    char_ready = 1'b1;
    wait_empty("t4_drain");
    hold(1'b0, 3);
    check("t4_valid_drop", char_valid, 1'b0);

    // Reset in the middle of a dash clears everything without a clock edge.
    hold(1'b1, 15);
    check("t6_btn_before", button_pressed, 1'b1);
    reset = 1'b1;
    #2;
    check("t6a_button",  button_pressed, 1'b0);
    check("t6a_symcnt",  sym_count,      3'd0);
    check("t6a_overrun", overrun,        1'b0);
    check("t6a_valid",   char_valid,     1'b0);
    hold(1'b0, 3);
    reset = 1'b0;
    hold(1'b0, 5);

    // Reset while a character is pending discards it.
    char_ready = 1'b0;
    hold(1'b1, 10); hold(1'b0, 35);
    check("t6_pending_valid", char_valid, 1'b1);
    check("t6_pending_ascii", ascii_char, 8'h45);
    reset = 1'b1;
    #2;
    check("t6b_valid", char_valid, 1'b0);
    check("t6b_ascii", ascii_char, 8'h00);
    hold(1'b0, 3);
    reset = 1'b0;
    hold(1'b0, 5);
    char_ready = 1'b1;
    exp_q.push_back(8'h45);
    hold(1'b1, 10); hold(1'b0, 35);
    exp_q.push_back(8'h20);
    hold(1'b0, 80);
    wait_empty("t6_drain");
    check("t6_overrun_end", overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
